// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RISC-V load/store funct3 codes and the access-size decoder.
package lsu_pkg;

    localparam int LSU_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_LO    = 3'd1,
        LD_HI    = 3'd2,
        ST_RD_LO = 3'd3,
        ST_WR_LO = 3'd4,
        ST_RD_HI = 3'd5,
        ST_WR_HI = 3'd6,
        RESP     = 3'd7
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size in bytes; 0 marks a funct3 that is not a load/store width.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = 3'd1;
            F3_H, F3_HU: size_of = 3'd2;
            F3_W:        size_of = 3'd4;
            default:     size_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_byte_lane.sv
// Combinational byte-lane steering: merges store bytes into a memory word and
// assembles/extends load bytes from a pair of adjacent memory words.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        offset,
    input  logic [2:0]        size,
    input  logic              hi_sel,
    output logic [DATA_W-1:0] merged,
    input  logic [DATA_W-1:0] ld_lo,
    input  logic [DATA_W-1:0] ld_hi,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] ld_result
);

    logic [2*DATA_W-1:0] window;
    logic [DATA_W-1:0]   raw;

    // Lane k of the hi word holds access byte (k + 4 - offset); of the lo word, (k - offset).
    always_comb begin
        int idx;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            idx = k - int'(offset) + (hi_sel ? 4 : 0);
            if (idx >= 0 && idx < int'(size)) begin
                merged[8*k +: 8] = st_data[8*idx +: 8];
            end
        end
    end

    always_comb begin
        window = {ld_hi, ld_lo};
        raw    = window[8*offset +: DATA_W];
        case (funct3)
            F3_B:    ld_result = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            F3_H:    ld_result = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            F3_BU:   ld_result = {{(DATA_W-8){1'b0}}, raw[7:0]};
            F3_HU:   ld_result = {{(DATA_W-16){1'b0}}, raw[15:0]};
            default: ld_result = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed DataMemory: turns byte
// addressed RISC-V loads/stores into word reads, read-modify-writes and splits.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W      = LSU_DATA_W,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;

    logic [2:0]        req_size, cur_size;
    logic              req_span, req_err, cur_span;
    logic [DATA_W-3:0] hi_idx;
    logic [DATA_W-1:0] merged, ld_result;

    always_comb begin
        req_size = size_of(req_funct3);
        req_span = ({1'b0, req_size} + {2'b00, req_addr[1:0]}) > 4'd4;
        req_err  = (req_size == 3'd0) || (req_we && req_funct3[2])
                   || (req_span && !MISALIGN_EN);
        cur_size = size_of(funct3_q);
        cur_span = ({1'b0, cur_size} + {2'b00, addr_q[1:0]}) > 4'd4;
        hi_idx   = addr_q[DATA_W-1:2] + {{(DATA_W-3){1'b0}}, 1'b1};
    end

    // Errors wait one cycle in LD_LO (read only, no write) so they report
    // with the same latency as an aligned access.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    lo_d     = '0;
                    hi_d     = '0;
                    if (req_err || !req_we) begin
                        state_d = LD_LO;
                    end else if (req_funct3 == F3_W && req_addr[1:0] == 2'b00) begin
                        state_d = ST_WR_LO;
                    end else begin
                        state_d = ST_RD_LO;
                    end
                end
            end
            LD_LO: begin
                lo_d    = mem_rdata;
                state_d = (cur_span && !err_q) ? LD_HI : RESP;
            end
            LD_HI: begin
                hi_d    = mem_rdata;
                state_d = RESP;
            end
            ST_RD_LO: begin
                lo_d    = mem_rdata;
                state_d = ST_WR_LO;
            end
            ST_WR_LO: state_d = cur_span ? ST_RD_HI : RESP;
            ST_RD_HI: begin
                hi_d    = mem_rdata;
                state_d = ST_WR_HI;
            end
            ST_WR_HI: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .old_word  ((state_q == ST_WR_HI) ? hi_q : lo_q),
        .st_data   (wdata_q),
        .offset    (addr_q[1:0]),
        .size      (cur_size),
        .hi_sel    (state_q == ST_WR_HI),
        .merged    (merged),
        .ld_lo     (lo_q),
        .ld_hi     (hi_q),
        .funct3    (funct3_q),
        .ld_result (ld_result)
    );

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = (state_q == RESP && !we_q && !err_q) ? ld_result : '0;
        mem_we     = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
        mem_wdata  = mem_we ? merged : '0;
        case (state_q)
            LD_LO, ST_RD_LO, ST_WR_LO: mem_addr = {2'b00, addr_q[DATA_W-1:2]};
            LD_HI, ST_RD_HI, ST_WR_HI: mem_addr = {2'b00, hi_idx};
            default:                   mem_addr = '0;
        endcase
    end

endmodule
